// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which requester owns the memory port
//   mem_cmd_t   : latched memory command presented on mem_*
//   pick_grant  : fixed-alternation choice between the two requesters
package cpu_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned WDT_W           = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_t;

    typedef enum logic {
        IF = 1'b0,
        D  = 1'b1
    } grant_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_cmd_t;

    // On contention the port that did not win last time gets the grant.
    function automatic grant_t pick_grant(input logic if_req, input logic d_req,
                                          input grant_t last);
        grant_t g;
        if (if_req && d_req) begin
            g = (last == IF) ? D : IF;
        end else if (if_req) begin
            g = IF;
        end else begin
            g = D;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_arb_wdt.sv
// Wait counter for an outstanding memory transaction.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force the count to zero (held while the arbiter is idle)
//   en         : count one more cycle of waiting
//   expired    : count has reached TIMEOUT-1
module mem_arb_wdt
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WDT_W-1:0] TC = WDT_W'(TIMEOUT - 1);

    logic [WDT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == TC);

endmodule

// File: rtl/mem_arb.sv
// Two-port arbiter in front of a single memory port: instruction fetch (if_*)
// and data load/store (d_*). One transaction in flight at a time; a
// transaction that gets no mem_ack within TIMEOUT cycles is aborted with err.
//   clk, rst_n                               : clock, synchronous active-low reset
//   if_req/if_addr -> if_ack/if_rdata        : fetch port
//   d_req/d_we/d_addr/d_wdata/d_wstrb
//                   -> d_ack/d_rdata         : data port
//   err                                      : accompanies an ack that was a timeout
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb, mem_ack/mem_rdata : memory port
//
// state   | meaning
// IDLE    | no transaction; grant on any request
// BUSY_IF | fetch transaction outstanding on memory port
// BUSY_D  | data transaction outstanding on memory port
module mem_arb
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ack,
    output logic [31:0] d_rdata,

    output logic        err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    arb_state_t state, state_nxt;
    grant_t     last_grant, last_grant_nxt;
    mem_cmd_t   cmd_q, cmd_nxt;
    logic       mem_req_nxt;
    logic       wdt_clr, wdt_en, wdt_expired;
    logic       done;
    logic [31:0] rdata_out;

    mem_arb_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wdt_clr),
        .en      (wdt_en),
        .expired (wdt_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= D;
            mem_req    <= 1'b0;
            cmd_q      <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            mem_req    <= mem_req_nxt;
            cmd_q      <= cmd_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        mem_req_nxt    = mem_req;
        cmd_nxt        = cmd_q;
        wdt_clr        = 1'b0;
        wdt_en         = 1'b0;
        done           = 1'b0;
        rdata_out      = 32'h0;
        if_ack         = 1'b0;
        d_ack          = 1'b0;
        if_rdata       = 32'h0;
        d_rdata        = 32'h0;
        err            = 1'b0;

        case (state)
            IDLE: begin
                // mem_ack here belongs to nothing and is deliberately ignored.
                wdt_clr = 1'b1;
                if (if_req || d_req) begin
                    mem_req_nxt = 1'b1;
                    if (pick_grant(if_req, d_req, last_grant) == IF) begin
                        state_nxt      = BUSY_IF;
                        last_grant_nxt = IF;
                        cmd_nxt.we     = 1'b0;
                        cmd_nxt.addr   = if_addr;
                        cmd_nxt.wdata  = 32'h0;
                        cmd_nxt.wstrb  = 4'h0;
                    end else begin
                        state_nxt      = BUSY_D;
                        last_grant_nxt = D;
                        cmd_nxt.we     = d_we;
                        cmd_nxt.addr   = d_addr;
                        cmd_nxt.wdata  = d_wdata;
                        cmd_nxt.wstrb  = d_wstrb;
                    end
                end
            end

            BUSY_IF, BUSY_D: begin
                wdt_en = ~mem_ack;
                // A real ack wins over a timeout landing in the same cycle.
                done   = mem_ack | wdt_expired;
                if (done) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    err         = ~mem_ack;
                    rdata_out   = mem_ack ? mem_rdata : 32'h0;
                    if (state == BUSY_IF) begin
                        if_ack   = 1'b1;
                        if_rdata = rdata_out;
                    end else begin
                        d_ack    = 1'b1;
                        d_rdata  = rdata_out;
                    end
                end
            end

            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_wstrb = cmd_q.wstrb;

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;
    import cpu_pkg::*;

    localparam int unsigned TO = 4;
    localparam logic [31:0] NOISE = 32'hBAD0_0BAD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // memory model: acks in BUSY cycle number mem_lat (0 = never); force_ack
    // injects a stray ack regardless of mem_req
    logic        resp_ack = 1'b0, force_ack = 1'b0;
    logic [31:0] resp_data = '0, force_data = '0, mem_data = '0;
    int          mem_lat = 0;
    int          busy_cnt = 0;

    assign mem_ack   = resp_ack | force_ack;
    assign mem_rdata = resp_ack ? resp_data : (force_ack ? force_data : NOISE);

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
        logic [31:0] addr;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arb #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always @(negedge clk) begin
        if (mem_req && mem_lat != 0) begin
            busy_cnt = busy_cnt + 1;
            if (busy_cnt == mem_lat) begin
                resp_ack  = 1'b1;
                resp_data = mem_data;
                busy_cnt  = 0;
            end else begin
                resp_ack  = 1'b0;
            end
        end else begin
            busy_cnt = 0;
            resp_ack = 1'b0;
        end
    end

    // Observation only: advances until either ack appears or budget runs out.
    task automatic wait_for_ack(input int budget, output bit got, output int cycles,
                                output bit is_d, output logic [31:0] rdata,
                                output bit e, output logic [31:0] addr);
        got = 0; cycles = 0; is_d = 0; rdata = '0; e = 0; addr = '0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk); #1;
            if (if_ack || d_ack) begin
                got = 1; cycles = i; is_d = d_ack;
                rdata = d_ack ? d_rdata : if_rdata;
                e = err; addr = mem_addr;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_ack, d_ack,
             if_rdata, d_rdata, err} !== '0 || dut.state !== IDLE || dut.last_grant !== D) begin
            n_errors++;
            $display("FAIL reset_state: mem_req=%b mem_addr=%h if_ack=%b d_ack=%b err=%b state=%0d last=%0d, want all 0 state=IDLE last=D",
                     mem_req, mem_addr, if_ack, d_ack, err, dut.state, dut.last_grant);
        end
    endtask

    task automatic test_round_robin();
        bit got, is_d, e; int cyc; logic [31:0] rd, ad; exp_t x;
        mem_lat = 2;
        if_addr = 32'h0000_1000;
        d_addr  = 32'h0000_2400;
        d_we    = 1'b0;
        for (int k = 0; k < 4; k++)
            sb.push_back('{is_d: (k % 2) == 1, rdata: 32'hA000_0000 + k, err: 0,
                           addr: (k % 2) == 1 ? 32'h0000_2400 : 32'h0000_1000});
        // both requests raised at the same time reset is released
        @(negedge clk);
        rst_n = 1'b1; if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_data = 32'hA000_0000 + k;
            wait_for_ack(10, got, cyc, is_d, rd, e, ad);
            x = sb.pop_front();
            n_checks++;
            if (!got || is_d !== x.is_d || rd !== x.rdata || e !== x.err || ad !== x.addr) begin
                n_errors++;
                $display("FAIL rr_grant%0d: got=%b port_d=%b rdata=%h err=%b addr=%h, want port_d=%b rdata=%h err=%b addr=%h",
                         k, got, is_d, rd, e, ad, x.is_d, x.rdata, x.err, x.addr);
            end
            @(negedge clk); #1;
            if (k == 3) begin if_req = 1'b0; d_req = 1'b0; end
            n_checks++;
            if (mem_req !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin
                n_errors++;
                $display("FAIL rr_idle_gap%0d: mem_req=%b if_ack=%b d_ack=%b, want 0 0 0",
                         k, mem_req, if_ack, d_ack);
            end
        end
    endtask

    task automatic test_if_read();
        bit got, is_d, e; int cyc; logic [31:0] rd, ad; exp_t x;
        mem_lat = 3; mem_data = 32'hDEAD_BEEF;
        if_addr = 32'h0000_0100;
        sb.push_back('{is_d: 0, rdata: 32'hDEAD_BEEF, err: 0, addr: 32'h0000_0100});
        if_req = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin
            n_errors++;
            $display("FAIL if_issue: mem_req=%b addr=%h we=%b wstrb=%h, want 1 00000100 0 0",
                     mem_req, mem_addr, mem_we, mem_wstrb);
        end
        wait_for_ack(10, got, cyc, is_d, rd, e, ad);
        if_req = 1'b0;
        x = sb.pop_front();
        n_checks++;
        if (!got || cyc != 2 || is_d !== x.is_d || rd !== x.rdata || e !== x.err || ad !== x.addr) begin
            n_errors++;
            $display("FAIL if_read: got=%b cyc=%0d port_d=%b rdata=%h err=%b, want cyc=2 port_d=0 rdata=%h err=0",
                     got, cyc, is_d, rd, e, x.rdata);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (if_ack !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h0) begin
                n_errors++;
                $display("FAIL if_single_pulse%0d: if_ack=%b mem_req=%b if_rdata=%h, want 0 0 0",
                         i, if_ack, mem_req, if_rdata);
            end
        end
    endtask

    task automatic test_store();
        bit stable = 1, stray = 0; int acks = 0, ack_cyc = 0; exp_t x;
        mem_lat = 3; mem_data = 32'h0;
        sb.push_back('{is_d: 1, rdata: 32'h0, err: 0, addr: 32'h0000_2000});
        d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
        d_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); #1;
            if (if_ack) stray = 1;
            if (acks == 0 && (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 ||
                              mem_wdata !== 32'h1234_5678 || mem_wstrb !== 4'hF))
                stable = 0;
            if (d_ack) begin
                acks++;
                if (acks == 1) begin
                    ack_cyc = i;
                    x = sb.pop_front();
                    n_checks++;
                    if (d_rdata !== x.rdata || err !== x.err || mem_addr !== x.addr) begin
                        n_errors++;
                        $display("FAIL store_ack: d_rdata=%h err=%b addr=%h, want %h %b %h",
                                 d_rdata, err, mem_addr, x.rdata, x.err, x.addr);
                    end
                    d_req = 1'b0; d_we = 1'b0;
                end
            end
        end
        n_checks++;
        if (!stable || stray || acks != 1 || ack_cyc != 3) begin
            n_errors++;
            $display("FAIL store_fields: stable=%b stray_if_ack=%b acks=%0d ack_cycle=%0d, want 1 0 1 3",
                     stable, stray, acks, ack_cyc);
        end
    endtask

    task automatic test_timeout();
        bit got, is_d, e; int cyc; logic [31:0] rd, ad; exp_t x;
        mem_lat = 0;
        sb.push_back('{is_d: 1, rdata: 32'h0, err: 1, addr: 32'h0000_3000});
        d_we = 1'b0; d_addr = 32'h0000_3000; d_req = 1'b1;
        wait_for_ack(10, got, cyc, is_d, rd, e, ad);
        d_req = 1'b0;
        x = sb.pop_front();
        n_checks++;
        if (!got || cyc != 4 || is_d !== x.is_d || rd !== x.rdata || e !== x.err || ad !== x.addr) begin
            n_errors++;
            $display("FAIL timeout_abort: got=%b cyc=%0d port_d=%b rdata=%h err=%b, want cyc=4 port_d=1 rdata=0 err=1",
                     got, cyc, is_d, rd, e);
        end
        @(negedge clk); #1;
        n_checks++;
        if (mem_req !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_release: mem_req=%b d_ack=%b err=%b, want 0 0 0", mem_req, d_ack, err);
        end
    endtask

    task automatic test_ack_at_timeout();
        bit got, is_d, e; int cyc; logic [31:0] rd, ad; exp_t x;
        mem_lat = 4; mem_data = 32'hCAFE_F00D;
        sb.push_back('{is_d: 0, rdata: 32'hCAFE_F00D, err: 0, addr: 32'h0000_0400});
        if_addr = 32'h0000_0400; if_req = 1'b1;
        wait_for_ack(10, got, cyc, is_d, rd, e, ad);
        if_req = 1'b0;
        x = sb.pop_front();
        n_checks++;
        if (!got || cyc != 4 || is_d !== x.is_d || rd !== x.rdata || e !== x.err || ad !== x.addr) begin
            n_errors++;
            $display("FAIL ack_at_timeout: got=%b cyc=%0d port_d=%b rdata=%h err=%b, want cyc=4 port_d=0 rdata=%h err=0",
                     got, cyc, is_d, rd, e, x.rdata);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset_abort();
        mem_lat = 0;
        if_addr = 32'h0000_0500; if_req = 1'b1;
        @(negedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || if_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_busy2: mem_req=%b if_ack=%b, want 1 0", mem_req, if_ack);
        end
        @(negedge clk);
        rst_n = 1'b1; if_req = 1'b0;
        force_data = 32'h1111_1111; force_ack = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_ack, d_ack,
             if_rdata, d_rdata, err} !== '0 || dut.state !== IDLE) begin
            n_errors++;
            $display("FAIL abort_after_reset: mem_req=%b mem_addr=%h if_ack=%b d_ack=%b err=%b state=%0d, want all 0 IDLE",
                     mem_req, mem_addr, if_ack, d_ack, err, dut.state);
        end
        @(negedge clk);
        force_ack = 1'b0;
        #1;
        n_checks++;
        if (dut.state !== IDLE || mem_req !== 1'b0 || if_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_late_ack: state=%0d mem_req=%b if_ack=%b, want IDLE 0 0",
                     dut.state, mem_req, if_ack);
        end
    endtask

    task automatic test_idle_ack();
        @(negedge clk);
        force_data = 32'h7777_7777; force_ack = 1'b1;
        #1;
        n_checks++;
        if (if_ack !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0 || if_rdata !== 32'h0 ||
            d_rdata !== 32'h0 || dut.state !== IDLE) begin
            n_errors++;
            $display("FAIL idle_ack: if_ack=%b d_ack=%b err=%b if_rdata=%h d_rdata=%h state=%0d, want 0s IDLE",
                     if_ack, d_ack, err, if_rdata, d_rdata, dut.state);
        end
        @(negedge clk);
        force_ack = 1'b0;
        #1;
        n_checks++;
        if (dut.state !== IDLE || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_ack_after: state=%0d mem_req=%b, want IDLE 0", dut.state, mem_req);
        end
    endtask

    initial begin
        #200000;
        n_errors++;
        $display("FAIL global_timeout: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_if_read();
        test_store();
        test_timeout();
        test_ack_at_timeout();
        test_reset_abort();
        test_idle_ack();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
